cgra_stream_ctrl: RTL and testbench
===================================

CGRA_STREAM_CTRL -- requirements
Module: cgra_stream_ctrl

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, meaning the data word width.
REQ-002 The block SHALL have parameter AWIDTH, default 10, meaning the BRAM word-address width.
REQ-003 The block SHALL have parameter NUM_CH, default 2, meaning the number of independent load/store channels (1..8).
REQ-004 The block SHALL have parameter BYTE_LEN, default 4, meaning the write-enable bits per channel.
REQ-005 The block SHALL have parameter WR_BASE, default 512, meaning the first store word address.
REQ-006 The block SHALL have port Clk  in  1  sole clock, all logic on rising edge.
REQ-007 The block SHALL have port Rst  in  1  reset, synchronous, active-high.
REQ-008 The block SHALL have port Computation_Start  in  1  software start level.
REQ-009 The block SHALL have port Computation_Done  out  1  done level.
REQ-010 The block SHALL have port Word_Count  in  AWIDTH+1  words per channel, latched at start.
REQ-011 The block SHALL have port Array_Start  out  1  one-cycle kick to the PE array.
REQ-012 The block SHALL have port Array_Busy  in  1  PE array busy.
REQ-013 The block SHALL have port Bram_En  out  NUM_CH  per-channel BRAM enable.
REQ-014 The block SHALL have port Bram_Wen  out  NUM_CH*BYTE_LEN  per-channel byte write enables.
REQ-015 The block SHALL have port Bram_Addr  out  NUM_CH*AWIDTH  per-channel word address.
REQ-016 The block SHALL have port Bram_Wr_Data  out  NUM_CH*DWIDTH  store data to BRAM.
REQ-017 The block SHALL have port Bram_Rd_Data  in  NUM_CH*DWIDTH  BRAM read data, 1-cycle latency.
REQ-018 The block SHALL have port Load_Data  out  NUM_CH*DWIDTH  data to the array.
REQ-019 The block SHALL have port Load_Valid  out  NUM_CH  Load_Data qualifier.
REQ-020 The block SHALL have port Store_Data  in  NUM_CH*DWIDTH  result data from the array.
REQ-021 The block SHALL have port Store_Valid  in  NUM_CH  Store_Data qualifier.
REQ-022 The block SHALL have port Store_Overflow  out  1  sticky excess-store flag.

Function
REQ-023 The FSM SHALL have states IDLE, KICK, RUN and DONE.
REQ-024 In IDLE with Computation_Start=1, the block SHALL latch Word_Count, clear all counters and Store_Overflow, then go to KICK, or to DONE if Word_Count=0.
REQ-025 KICK SHALL last exactly one cycle with Array_Start=1, then go to RUN; Array_Start SHALL be 0 in every other state.
REQ-026 In RUN, each channel c SHALL issue one read per cycle at address rd_cnt[c] (starting at 0) while rd_cnt[c] < count: Bram_En[c]=1, Wen=0, rd_cnt[c]+1.
REQ-027 Load_Valid[c] SHALL assert exactly one cycle after each issued read, with Load_Data[c]=Bram_Rd_Data[c].
REQ-028 Store_Valid[c]=1 with wr_cnt[c] < count SHALL write Store_Data[c] to address WR_BASE+wr_cnt[c], modulo 2^AWIDTH: Bram_En[c]=1, Wen all ones, wr_cnt[c]+1.
REQ-029 A store and a pending read on the same channel in the same cycle SHALL be resolved in favour of the store; that read SHALL stall one cycle with rd_cnt unchanged.
REQ-030 Store_Valid[c]=1 with wr_cnt[c]=count SHALL produce no write and SHALL set Store_Overflow, which stays set until the next start.
REQ-031 RUN SHALL go to DONE when every wr_cnt[c] equals count and Array_Busy=0 in the same cycle.
REQ-032 In DONE, Computation_Done SHALL be 1; the block SHALL return to IDLE on the first cycle with Computation_Start=0, and Computation_Done SHALL be 0 in IDLE.
REQ-033 Channels SHALL operate independently, with no cross-channel ordering.
REQ-034 Computation_Start going low during KICK or RUN SHALL not abort the operation.

Reset
REQ-035 Rst=1 at any clock edge, including mid-RUN, SHALL force IDLE and clear all counters and Store_Overflow.
REQ-036 On the same edge, Rst SHALL drive Array_Start, Computation_Done, Bram_En, Bram_Wen and Load_Valid to 0, and Bram_Addr and Bram_Wr_Data to 0.
REQ-037 No BRAM write SHALL occur in the cycle that Rst is sampled high.

Verification
REQ-038 Check NUM_CH=2, Word_Count=4, array echoing loads as stores after 3 cycles -> addresses 0..3 are read, writes land at 512..515, and Done rises one cycle after the last store once Busy=0.
REQ-039 Check Word_Count=0 -> no Array_Start, no Bram_En, and Done=1 two cycles after Start.
REQ-040 Check a store coinciding with a read on ch0 -> the write is issued, the read is delayed one cycle, and ch1 is unaffected.
REQ-041 Check five stores on Word_Count=4 -> four writes occur, Store_Overflow=1, and it is cleared by the next start.
REQ-042 Check Rst pulse mid-RUN -> all outputs are 0 the next cycle, and a new Start runs cleanly from address 0.
REQ-043 Check Start held high after DONE -> Done stays 1 with no restart; Start low gives IDLE and Done=0.

Source files
------------

// File: rtl/cgra_stream_ctrl.sv
// Stream controller between per-channel BRAMs and a CGRA PE array: kicks the array,
// streams loads out of BRAM word 0 upward and writes array results back from WR_BASE.
module cgra_stream_ctrl #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 10,
  parameter int NUM_CH   = 2,
  parameter int BYTE_LEN = 4,
  parameter int WR_BASE  = 512
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Computation_Start,
  output logic                       Computation_Done,
  input  logic [AWIDTH:0]            Word_Count,
  output logic                       Array_Start,
  input  logic                       Array_Busy,
  output logic [NUM_CH-1:0]          Bram_En,
  output logic [NUM_CH*BYTE_LEN-1:0] Bram_Wen,
  output logic [NUM_CH*AWIDTH-1:0]   Bram_Addr,
  output logic [NUM_CH*DWIDTH-1:0]   Bram_Wr_Data,
  input  logic [NUM_CH*DWIDTH-1:0]   Bram_Rd_Data,
  output logic [NUM_CH*DWIDTH-1:0]   Load_Data,
  output logic [NUM_CH-1:0]          Load_Valid,
  input  logic [NUM_CH*DWIDTH-1:0]   Store_Data,
  input  logic [NUM_CH-1:0]          Store_Valid,
  output logic                       Store_Overflow
);

  typedef enum logic [1:0] {IDLE, KICK, RUN, DONE} state_t;

  localparam logic [AWIDTH-1:0] WR_BASE_A = AWIDTH'(WR_BASE);
  localparam logic [AWIDTH:0]   CNT_ONE   = {{AWIDTH{1'b0}}, 1'b1};

  state_t          state;
  logic [AWIDTH:0] count;
  logic [AWIDTH:0] rd_cnt [NUM_CH];
  logic [AWIDTH:0] wr_cnt [NUM_CH];
  logic            all_written;

  // BRAM read data arrives one cycle after the issued read, exactly when Load_Valid is up
  assign Load_Data = Bram_Rd_Data;

  always_comb begin
    all_written = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_cnt[c] != count) all_written = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state            <= IDLE;
      count            <= '0;
      Array_Start      <= 1'b0;
      Computation_Done <= 1'b0;
      Store_Overflow   <= 1'b0;
      Bram_En          <= '0;
      Bram_Wen         <= '0;
      Bram_Addr        <= '0;
      Bram_Wr_Data     <= '0;
      Load_Valid       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        rd_cnt[c] <= '0;
        wr_cnt[c] <= '0;
      end
    end else begin
      Array_Start <= 1'b0;
      Bram_En     <= '0;
      Bram_Wen    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        Load_Valid[c] <= Bram_En[c] && (Bram_Wen[c*BYTE_LEN +: BYTE_LEN] == '0);
      end
      case (state)
        IDLE: begin
          Computation_Done <= 1'b0;
          if (Computation_Start) begin
            count          <= Word_Count;
            Store_Overflow <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
              rd_cnt[c] <= '0;
              wr_cnt[c] <= '0;
            end
            if (Word_Count == '0) begin
              state            <= DONE;
              Computation_Done <= 1'b1;
            end else begin
              state       <= KICK;
              Array_Start <= 1'b1;
            end
          end
        end
        KICK: state <= RUN;
        RUN: begin
          // Stores take the BRAM port first; a read that loses simply retries next cycle
          for (int c = 0; c < NUM_CH; c++) begin
            if (Store_Valid[c] && (wr_cnt[c] < count)) begin
              Bram_En[c]                            <= 1'b1;
              Bram_Wen[c*BYTE_LEN +: BYTE_LEN]      <= {BYTE_LEN{1'b1}};
              Bram_Addr[c*AWIDTH +: AWIDTH]         <= WR_BASE_A + wr_cnt[c][AWIDTH-1:0];
              Bram_Wr_Data[c*DWIDTH +: DWIDTH]      <= Store_Data[c*DWIDTH +: DWIDTH];
              wr_cnt[c]                             <= wr_cnt[c] + CNT_ONE;
            end else begin
              if (Store_Valid[c]) Store_Overflow <= 1'b1;
              if (rd_cnt[c] < count) begin
                Bram_En[c]                    <= 1'b1;
                Bram_Addr[c*AWIDTH +: AWIDTH] <= rd_cnt[c][AWIDTH-1:0];
                rd_cnt[c]                     <= rd_cnt[c] + CNT_ONE;
              end
            end
          end
          if (all_written && !Array_Busy) begin
            state            <= DONE;
            Computation_Done <= 1'b1;
          end
        end
        DONE: begin
          if (!Computation_Start) begin
            state            <= IDLE;
            Computation_Done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_stream_ctrl.sv
// Directed bench for cgra_stream_ctrl: behavioural BRAM and echoing PE array around the DUT,
// one task per scenario with hand-derived expectations.
module tb_cgra_stream_ctrl;

  logic        Clk;
  logic        Rst;
  logic        Computation_Start;
  logic        Computation_Done;
  logic [10:0] Word_Count;
  logic        Array_Start;
  logic        Array_Busy;
  logic [1:0]  Bram_En;
  logic [7:0]  Bram_Wen;
  logic [19:0] Bram_Addr;
  logic [63:0] Bram_Wr_Data;
  logic [63:0] Bram_Rd_Data;
  logic [63:0] Load_Data;
  logic [1:0]  Load_Valid;
  logic [63:0] Store_Data;
  logic [1:0]  Store_Valid;
  logic        Store_Overflow;

  cgra_stream_ctrl #(
    .DWIDTH(32), .AWIDTH(10), .NUM_CH(2), .BYTE_LEN(4), .WR_BASE(512)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Computation_Start(Computation_Start),
    .Computation_Done(Computation_Done), .Word_Count(Word_Count),
    .Array_Start(Array_Start), .Array_Busy(Array_Busy), .Bram_En(Bram_En),
    .Bram_Wen(Bram_Wen), .Bram_Addr(Bram_Addr), .Bram_Wr_Data(Bram_Wr_Data),
    .Bram_Rd_Data(Bram_Rd_Data), .Load_Data(Load_Data), .Load_Valid(Load_Valid),
    .Store_Data(Store_Data), .Store_Valid(Store_Valid), .Store_Overflow(Store_Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Memory contents are a fixed function of channel and address
  function automatic logic [31:0] pat(input int c, input logic [9:0] a);
    return 32'hA500_0000 + (32'(c) << 16) + {22'h0, a};
  endfunction

  logic [31:0] rd_word [2];
  always @(posedge Clk) begin
    for (int c = 0; c < 2; c++) begin
      if (Bram_En[c] && Bram_Wen[c*4 +: 4] == 4'h0) rd_word[c] <= pat(c, Bram_Addr[c*10 +: 10]);
    end
  end
  assign Bram_Rd_Data = {rd_word[1], rd_word[0]};

  // PE array stand-in: every load comes back as a store three cycles later
  logic        echo_on;
  logic [1:0]  sv_drv;
  logic [63:0] sd_drv;
  logic [1:0]  e_v1, e_v2, e_v3;
  logic [63:0] e_d1, e_d2, e_d3;
  always @(posedge Clk) begin
    e_v1 <= Load_Valid; e_d1 <= Load_Data;
    e_v2 <= e_v1;       e_d2 <= e_d1;
    e_v3 <= e_v2;       e_d3 <= e_d2;
  end
  assign Store_Valid = echo_on ? e_v3 : sv_drv;
  assign Store_Data  = echo_on ? e_d3 : sd_drv;

  int          cyc;
  int          n_kick, done_cyc, any_en;
  int          n_rd [2];
  int          n_wr [2];
  int          n_ld [2];
  int          rd_addr [2][16];
  int          rd_cyc [2][16];
  int          wr_addr [2][16];
  int          wr_cyc [2][16];
  logic [31:0] wr_data [2][16];
  logic [31:0] ld_data [2][16];

  task automatic mon_clear();
    n_kick = 0; done_cyc = -1; any_en = 0;
    for (int c = 0; c < 2; c++) begin
      n_rd[c] = 0; n_wr[c] = 0; n_ld[c] = 0;
      for (int k = 0; k < 16; k++) begin
        rd_addr[c][k] = 0; rd_cyc[c][k] = 0; wr_addr[c][k] = 0; wr_cyc[c][k] = 0;
        wr_data[c][k] = '0; ld_data[c][k] = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    cyc++;
    #1;
    if (Array_Start === 1'b1) n_kick++;
    if (Computation_Done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    if (Bram_En !== 2'b00) any_en = 1;
    for (int c = 0; c < 2; c++) begin
      if (Bram_En[c] && Bram_Wen[c*4 +: 4] == 4'h0 && n_rd[c] < 16) begin
        rd_addr[c][n_rd[c]] = int'(Bram_Addr[c*10 +: 10]); rd_cyc[c][n_rd[c]] = cyc; n_rd[c]++;
      end
      if (Bram_En[c] && Bram_Wen[c*4 +: 4] == 4'hF && n_wr[c] < 16) begin
        wr_addr[c][n_wr[c]] = int'(Bram_Addr[c*10 +: 10]); wr_cyc[c][n_wr[c]] = cyc;
        wr_data[c][n_wr[c]] = Bram_Wr_Data[c*32 +: 32]; n_wr[c]++;
      end
      if (Load_Valid[c] && n_ld[c] < 16) begin
        ld_data[c][n_ld[c]] = Load_Data[c*32 +: 32]; n_ld[c]++;
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) tick();
    checks++; if ({Array_Start, Computation_Done, Bram_En, Bram_Wen, Load_Valid, Store_Overflow} !== 15'h0) begin
      errors++; $display("FAIL reset_ctrl got %h want 0", {Array_Start, Computation_Done, Bram_En, Bram_Wen, Load_Valid, Store_Overflow}); end
    checks++; if (Bram_Addr !== 20'h0) begin errors++; $display("FAIL reset_addr got %h want 0", Bram_Addr); end
    checks++; if (Bram_Wr_Data !== 64'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", Bram_Wr_Data); end
    Rst = 1'b0;
    tick();
    checks++; if ({Array_Start, Computation_Done, Bram_En} !== 4'h0) begin
      errors++; $display("FAIL reset_idle got %h want 0", {Array_Start, Computation_Done, Bram_En}); end
  endtask

  task automatic test_main();
    int last;
    mon_clear();
    echo_on = 1'b1; Array_Busy = 1'b0; Word_Count = 11'd4; Computation_Start = 1'b1;
    tick(); tick();
    Computation_Start = 1'b0;
    repeat (25) tick();
    checks++; if (n_kick !== 1) begin errors++; $display("FAIL main_kick got %0d want 1", n_kick); end
    for (int c = 0; c < 2; c++) begin
      checks++; if (n_rd[c] !== 4) begin errors++; $display("FAIL main_nrd ch%0d got %0d want 4", c, n_rd[c]); end
      checks++; if (n_wr[c] !== 4) begin errors++; $display("FAIL main_nwr ch%0d got %0d want 4", c, n_wr[c]); end
      checks++; if (n_ld[c] !== 4) begin errors++; $display("FAIL main_nld ch%0d got %0d want 4", c, n_ld[c]); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (rd_addr[c][k] !== k) begin
          errors++; $display("FAIL main_rd_addr ch%0d[%0d] got %0d want %0d", c, k, rd_addr[c][k], k); end
        checks++; if (wr_addr[c][k] !== 512 + k) begin
          errors++; $display("FAIL main_wr_addr ch%0d[%0d] got %0d want %0d", c, k, wr_addr[c][k], 512 + k); end
        checks++; if (wr_data[c][k] !== pat(c, 10'(k))) begin
          errors++; $display("FAIL main_wr_data ch%0d[%0d] got %h want %h", c, k, wr_data[c][k], pat(c, 10'(k))); end
        checks++; if (ld_data[c][k] !== pat(c, 10'(k))) begin
          errors++; $display("FAIL main_ld_data ch%0d[%0d] got %h want %h", c, k, ld_data[c][k], pat(c, 10'(k))); end
      end
    end
    last = (wr_cyc[0][3] > wr_cyc[1][3]) ? wr_cyc[0][3] : wr_cyc[1][3];
    checks++; if (done_cyc !== last + 1) begin
      errors++; $display("FAIL main_done_cycle got %0d want %0d", done_cyc, last + 1); end
    checks++; if (Computation_Done !== 1'b0) begin
      errors++; $display("FAIL main_done_idle got %b want 0", Computation_Done); end
  endtask

  task automatic test_zero_count();
    mon_clear();
    echo_on = 1'b0; sv_drv = 2'b00; Word_Count = 11'd0; Computation_Start = 1'b1;
    tick(); tick();
    checks++; if (Computation_Done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", Computation_Done); end
    checks++; if (n_kick !== 0) begin errors++; $display("FAIL zero_kick got %0d want 0", n_kick); end
    checks++; if (any_en !== 0) begin errors++; $display("FAIL zero_bram_en got %0d want 0", any_en); end
    Computation_Start = 1'b0;
    tick();
    checks++; if (Computation_Done !== 1'b0) begin errors++; $display("FAIL zero_done_clr got %b want 0", Computation_Done); end
  endtask

  task automatic test_store_read_conflict();
    mon_clear();
    echo_on = 1'b0; sv_drv = 2'b00; Array_Busy = 1'b1; Word_Count = 11'd4; Computation_Start = 1'b1;
    tick();
    Computation_Start = 1'b0;
    for (int i = 0; i < 10 && n_rd[0] == 0; i++) tick();
    checks++; if (n_rd[0] !== 1) begin errors++; $display("FAIL conf_first_read got %0d want 1", n_rd[0]); end
    sv_drv = 2'b01; sd_drv = 64'h0000_0000_DEAD_0001;
    tick();
    sv_drv = 2'b00;
    repeat (5) tick();
    checks++; if (n_wr[0] !== 1) begin errors++; $display("FAIL conf_nwr0 got %0d want 1", n_wr[0]); end
    checks++; if (wr_addr[0][0] !== 512) begin errors++; $display("FAIL conf_wr_addr got %0d want 512", wr_addr[0][0]); end
    checks++; if (wr_data[0][0] !== 32'hDEAD_0001) begin errors++; $display("FAIL conf_wr_data got %h want DEAD0001", wr_data[0][0]); end
    checks++; if (wr_cyc[0][0] !== rd_cyc[0][0] + 1) begin
      errors++; $display("FAIL conf_wr_cycle got %0d want %0d", wr_cyc[0][0], rd_cyc[0][0] + 1); end
    checks++; if (rd_addr[0][1] !== 1) begin errors++; $display("FAIL conf_rd1_addr got %0d want 1", rd_addr[0][1]); end
    checks++; if (rd_cyc[0][1] !== rd_cyc[0][0] + 2) begin
      errors++; $display("FAIL conf_rd1_cycle got %0d want %0d", rd_cyc[0][1], rd_cyc[0][0] + 2); end
    checks++; if (n_rd[0] !== 4 || rd_addr[0][3] !== 3) begin
      errors++; $display("FAIL conf_ch0_reads got n=%0d last=%0d want n=4 last=3", n_rd[0], rd_addr[0][3]); end
    checks++; if (n_wr[1] !== 0) begin errors++; $display("FAIL conf_nwr1 got %0d want 0", n_wr[1]); end
    checks++; if (rd_cyc[1][1] !== rd_cyc[1][0] + 1 || rd_addr[1][1] !== 1) begin
      errors++; $display("FAIL conf_ch1_read got cyc=%0d addr=%0d want cyc=%0d addr=1", rd_cyc[1][1], rd_addr[1][1], rd_cyc[1][0] + 1); end
    Rst = 1'b1; tick(); Rst = 1'b0; tick();
  endtask

  task automatic test_overflow();
    mon_clear();
    echo_on = 1'b0; sv_drv = 2'b00; Array_Busy = 1'b1; Word_Count = 11'd4; Computation_Start = 1'b1;
    tick();
    Computation_Start = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      sv_drv = 2'b01; sd_drv = {32'h0, 32'h5100 + 32'(k)};
      tick();
    end
    sv_drv = 2'b00;
    checks++; if (Store_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", Store_Overflow); end
    checks++; if (n_wr[0] !== 4) begin errors++; $display("FAIL ovf_nwr got %0d want 4", n_wr[0]); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (wr_addr[0][k] !== 512 + k || wr_data[0][k] !== 32'h5100 + 32'(k)) begin
        errors++; $display("FAIL ovf_write[%0d] got %0d/%h want %0d/%h", k, wr_addr[0][k], wr_data[0][k], 512 + k, 32'h5100 + 32'(k)); end
    end
    Array_Busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sv_drv = 2'b10; sd_drv = {32'h6100 + 32'(k), 32'h0};
      tick();
    end
    sv_drv = 2'b00;
    for (int i = 0; i < 10 && Computation_Done !== 1'b1; i++) tick();
    checks++; if (Computation_Done !== 1'b1) begin errors++; $display("FAIL ovf_done got %b want 1", Computation_Done); end
    checks++; if (Store_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky_done got %b want 1", Store_Overflow); end
    tick();
    checks++; if (Store_Overflow !== 1'b1 || Computation_Done !== 1'b0) begin
      errors++; $display("FAIL ovf_sticky_idle got ovf=%b done=%b want ovf=1 done=0", Store_Overflow, Computation_Done); end
    Word_Count = 11'd0; Computation_Start = 1'b1;
    tick();
    checks++; if (Store_Overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", Store_Overflow); end
    Computation_Start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    mon_clear();
    echo_on = 1'b1; Array_Busy = 1'b1; Word_Count = 11'd4; Computation_Start = 1'b1;
    tick();
    Computation_Start = 1'b0;
    repeat (4) tick();
    Rst = 1'b1;
    tick();
    checks++; if ({Array_Start, Computation_Done, Bram_En, Bram_Wen, Load_Valid, Store_Overflow} !== 15'h0) begin
      errors++; $display("FAIL rstmid_ctrl got %h want 0", {Array_Start, Computation_Done, Bram_En, Bram_Wen, Load_Valid, Store_Overflow}); end
    checks++; if (Bram_Addr !== 20'h0 || Bram_Wr_Data !== 64'h0) begin
      errors++; $display("FAIL rstmid_bus got addr=%h data=%h want 0", Bram_Addr, Bram_Wr_Data); end
    Rst = 1'b0; Array_Busy = 1'b0;
    repeat (5) tick();
    mon_clear();
    Computation_Start = 1'b1;
    tick();
    Computation_Start = 1'b0;
    repeat (20) tick();
    for (int c = 0; c < 2; c++) begin
      checks++; if (n_rd[c] !== 4 || rd_addr[c][0] !== 0) begin
        errors++; $display("FAIL rstmid_rerun_rd ch%0d got n=%0d first=%0d want n=4 first=0", c, n_rd[c], rd_addr[c][0]); end
      checks++; if (n_wr[c] !== 4 || wr_addr[c][0] !== 512 || wr_data[c][0] !== pat(c, 10'd0)) begin
        errors++; $display("FAIL rstmid_rerun_wr ch%0d got n=%0d addr=%0d data=%h want n=4 addr=512 data=%h", c, n_wr[c], wr_addr[c][0], wr_data[c][0], pat(c, 10'd0)); end
    end
    checks++; if (done_cyc < 0) begin errors++; $display("FAIL rstmid_rerun_done got %0d want >=0", done_cyc); end
  endtask

  task automatic test_start_held();
    mon_clear();
    echo_on = 1'b1; Array_Busy = 1'b0; Word_Count = 11'd2; Computation_Start = 1'b1;
    for (int i = 0; i < 30 && Computation_Done !== 1'b1; i++) tick();
    checks++; if (Computation_Done !== 1'b1) begin errors++; $display("FAIL held_done got %b want 1", Computation_Done); end
    repeat (4) tick();
    checks++; if (Computation_Done !== 1'b1) begin errors++; $display("FAIL held_done_stays got %b want 1", Computation_Done); end
    checks++; if (n_kick !== 1) begin errors++; $display("FAIL held_no_restart got %0d kicks want 1", n_kick); end
    Computation_Start = 1'b0;
    tick();
    checks++; if (Computation_Done !== 1'b0) begin errors++; $display("FAIL held_release got %b want 0", Computation_Done); end
    tick();
    checks++; if ({Computation_Done, Array_Start, Bram_En} !== 4'h0) begin
      errors++; $display("FAIL held_idle got %h want 0", {Computation_Done, Array_Start, Bram_En}); end
  endtask

  initial begin
    cyc = 0;
    Rst = 1'b1; Computation_Start = 1'b0; Array_Busy = 1'b0; Word_Count = 11'd0;
    echo_on = 1'b0; sv_drv = 2'b00; sd_drv = 64'h0;
    mon_clear();
    test_reset();
    test_main();
    test_zero_count();
    test_store_read_conflict();
    test_overflow();
    test_reset_mid_run();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
